// File: rtl/exercise3_unpacker.sv
// Three-word frame unpacker: a sync-checked header carrying field a, then words b and c.
// The frame is held on a valid/ready output until the downstream side takes it.
module exercise3_unpacker #(
  parameter logic [3:0] SYNC = 4'hA
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  a,
  output logic [15:0] b,
  output logic [15:0] c,
  output logic        frame_err,
  output logic [7:0]  err_count,
  output logic [7:0]  frame_count
);

  typedef enum logic [1:0] {HDR, WB, WC, HOLD} state_t;

  state_t state;
  logic   in_beat;
  logic   hdr_ok;

  always_comb begin
    in_beat = in_valid & in_ready;
    hdr_ok  = (in_data[15:12] == SYNC) && (in_data[11:4] == 8'h00);
  end

  // nReset is active-high despite its name.
  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      state       <= HDR;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      frame_err   <= 1'b0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      err_count   <= '0;
      frame_count <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        HDR: begin
          if (in_beat) begin
            if (hdr_ok) begin
              a     <= in_data[3:0];
              state <= WB;
            end else begin
              frame_err <= 1'b1;
              if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            end
          end
        end
        WB: begin
          if (in_beat) begin
            b     <= in_data;
            state <= WC;
          end
        end
        WC: begin
          // in_ready/out_valid are registered, so they switch together with the state.
          if (in_beat) begin
            c         <= in_data;
            state     <= HOLD;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state       <= HDR;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            frame_count <= frame_count + 8'd1;
          end
        end
        default: begin
          state     <= HDR;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exercise3_unpacker.sv
// Self-checking bench for exercise3_unpacker: directed frames plus randomized frames,
// bad headers, stalls and downstream back-pressure, checked against a frame-level model.
module tb_exercise3_unpacker;

  localparam logic [3:0] SYNC = 4'hA;

  logic        clk = 1'b0;
  logic        nReset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  a;
  logic [15:0] b;
  logic [15:0] c;
  logic        frame_err;
  logic [7:0]  err_count;
  logic [7:0]  frame_count;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Frame-level expectations.
  int unsigned exp_err = 0;
  int unsigned exp_frames = 0;
  logic        rand_ordy = 1'b0;

  exercise3_unpacker #(.SYNC(SYNC)) dut (
    .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .c(c), .frame_err(frame_err),
    .err_count(err_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  function automatic bit hdr_ok(input logic [15:0] w);
    return (w[15:12] == SYNC) && (w[11:4] == 8'h00);
  endfunction

  function automatic logic [15:0] bad_word();
    logic [15:0] w;
    if ($urandom_range(0, 1) == 0)
      w = {SYNC, 8'(8'h01 << $urandom_range(0, 7)), 4'($urandom)};
    else
      w = 16'($urandom);
    if (hdr_ok(w)) w[11] = ~w[11];
    return w;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for acceptance after some idle (in_valid=0) cycles.
  task automatic beat(input logic [15:0] w, input int unsigned stalls);
    for (int unsigned i = 0; i < stalls; i++) begin
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      if (rand_ordy) out_ready = 1'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = w;
    if (rand_ordy) out_ready = 1'($urandom);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    nReset = 1'b1;
    @(negedge clk);
    nReset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    exp_err = 0;
    exp_frames = 0;
  endtask

  task automatic test_reset();
    #12;
    n_total++;
    if ({out_valid, in_ready, frame_err} !== 3'b010)
      $display("FAIL reset_flags: got %b expected 010", {out_valid, in_ready, frame_err});
    else n_pass++;
    n_total++;
    if ({a, b, c, err_count, frame_count} !== 52'h0)
      $display("FAIL reset_fields: got a=%h b=%h c=%h err=%0d frm=%0d expected all 0",
               a, b, c, err_count, frame_count);
    else n_pass++;
    @(negedge clk);
    nReset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    beat(16'hA005, 0);
    beat(16'h1234, 0);
    beat(16'hBEEF, 0);
    n_total++;
    if ({out_valid, in_ready} !== 2'b10 || a !== 4'h5 || b !== 16'h1234 || c !== 16'hBEEF)
      $display("FAIL basic_out: got v=%b r=%b a=%h b=%h c=%h expected v=1 r=0 a=5 b=1234 c=beef",
               out_valid, in_ready, a, b, c);
    else n_pass++;
    tick();
    exp_frames++;
    n_total++;
    if ({out_valid, in_ready} !== 2'b01 || frame_count !== 8'(exp_frames))
      $display("FAIL basic_handoff: got v=%b r=%b frm=%0d expected v=0 r=1 frm=%0d",
               out_valid, in_ready, frame_count, exp_frames);
    else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_bad_header();
    beat(16'h5005, 0);
    exp_err = sat_inc(exp_err);
    n_total++;
    if (frame_err !== 1'b1 || err_count !== 8'(exp_err))
      $display("FAIL badhdr_pulse: got err=%b cnt=%0d expected err=1 cnt=%0d",
               frame_err, err_count, exp_err);
    else n_pass++;
    tick();
    n_total++;
    if (frame_err !== 1'b0 || err_count !== 8'(exp_err))
      $display("FAIL badhdr_oneshot: got err=%b cnt=%0d expected err=0 cnt=%0d",
               frame_err, err_count, exp_err);
    else n_pass++;
    beat(16'hA00F, 0);
    beat(16'h0001, 0);
    beat(16'h0002, 0);
    n_total++;
    if (out_valid !== 1'b1 || a !== 4'hF || b !== 16'h0001 || c !== 16'h0002 || frame_err !== 1'b0)
      $display("FAIL badhdr_frame: got v=%b a=%h b=%h c=%h err=%b expected v=1 a=f b=0001 c=0002 err=0",
               out_valid, a, b, c, frame_err);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_frames++;
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    beat(16'hA007, 1);
    beat(16'hCAFE, 0);
    beat(16'hF00D, 2);
    for (int unsigned i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      tick();
      n_total++;
      if ({out_valid, in_ready, frame_err} !== 3'b100 || a !== 4'h7 || b !== 16'hCAFE ||
          c !== 16'hF00D || frame_count !== 8'(exp_frames))
        $display("FAIL hold_stable: got v=%b r=%b e=%b a=%h b=%h c=%h frm=%0d expected v=1 r=0 e=0 a=7 b=cafe c=f00d frm=%0d",
                 out_valid, in_ready, frame_err, a, b, c, frame_count, exp_frames);
      else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_frames++;
    n_total++;
    if ({out_valid, in_ready} !== 2'b01 || frame_count !== 8'(exp_frames) ||
        a !== 4'h7 || b !== 16'hCAFE || c !== 16'hF00D)
      $display("FAIL hold_handoff: got v=%b r=%b frm=%0d a=%h b=%h c=%h expected v=0 r=1 frm=%0d fields kept",
               out_valid, in_ready, frame_count, a, b, c, exp_frames);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    beat(16'hA003, 0);
    beat(16'h5555, 0);
    #2;
    nReset = 1'b1;
    #1;
    n_total++;
    if ({out_valid, in_ready, frame_err} !== 3'b010 || {a, b, c, err_count, frame_count} !== 52'h0)
      $display("FAIL reset_mid: got v=%b r=%b e=%b a=%h b=%h c=%h err=%0d frm=%0d expected all idle/0",
               out_valid, in_ready, frame_err, a, b, c, err_count, frame_count);
    else n_pass++;
    @(negedge clk);
    nReset = 1'b0;
    tick();
    exp_err = 0;
    exp_frames = 0;
    beat(16'hA00C, 0);
    n_total++;
    if (frame_err !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL reset_first_hdr: got e=%b v=%b expected e=0 v=0", frame_err, out_valid);
    else n_pass++;
    beat(16'h1111, 0);
    beat(16'h2222, 0);
    n_total++;
    if (out_valid !== 1'b1 || a !== 4'hC || b !== 16'h1111 || c !== 16'h2222)
      $display("FAIL reset_fresh: got v=%b a=%h b=%h c=%h expected v=1 a=c b=1111 c=2222",
               out_valid, a, b, c);
    else n_pass++;
    // Reset while holding a frame: nothing delivered, nothing counted.
    #2;
    nReset = 1'b1;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || frame_count !== 8'h00 || {a, b, c} !== 36'h0)
      $display("FAIL reset_hold: got v=%b frm=%0d a=%h b=%h c=%h expected v=0 frm=0 fields 0",
               out_valid, frame_count, a, b, c);
    else n_pass++;
    @(negedge clk);
    nReset = 1'b0;
    tick();
  endtask

  task automatic test_random(input int unsigned nframes);
    logic [15:0] w, hb, hc;
    logic [3:0]  ha;
    int unsigned nbad, waits;
    rand_ordy = 1'b1;
    for (int unsigned f = 0; f < nframes; f++) begin
      nbad = $urandom_range(0, 2);
      for (int unsigned k = 0; k < nbad; k++) begin
        w = bad_word();
        beat(w, $urandom_range(0, 2));
        exp_err = sat_inc(exp_err);
        n_total++;
        if (frame_err !== 1'b1 || err_count !== 8'(exp_err) || out_valid !== 1'b0)
          $display("FAIL rand_bad: word=%h got e=%b cnt=%0d v=%b expected e=1 cnt=%0d v=0",
                   w, frame_err, err_count, out_valid, exp_err);
        else n_pass++;
      end
      ha = 4'($urandom);
      hb = 16'($urandom);
      hc = 16'($urandom);
      beat({SYNC, 8'h00, ha}, $urandom_range(0, 3));
      beat(hb, $urandom_range(0, 3));
      beat(hc, $urandom_range(0, 3));
      n_total++;
      if ({out_valid, in_ready, frame_err} !== 3'b100 || a !== ha || b !== hb || c !== hc)
        $display("FAIL rand_frame: got v=%b r=%b e=%b a=%h b=%h c=%h expected v=1 r=0 e=0 a=%h b=%h c=%h",
                 out_valid, in_ready, frame_err, a, b, c, ha, hb, hc);
      else n_pass++;
      out_ready = 1'b0;
      waits = $urandom_range(0, 3);
      for (int unsigned i = 0; i < waits; i++) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_frames = (exp_frames + 1) % 256;
      n_total++;
      if ({out_valid, in_ready} !== 2'b01 || frame_count !== 8'(exp_frames) ||
          err_count !== 8'(exp_err) || a !== ha || b !== hb || c !== hc)
        $display("FAIL rand_handoff: got v=%b r=%b frm=%0d err=%0d a=%h b=%h c=%h expected v=0 r=1 frm=%0d err=%0d a=%h b=%h c=%h",
                 out_valid, in_ready, frame_count, err_count, a, b, c,
                 exp_frames, exp_err, ha, hb, hc);
      else n_pass++;
    end
    rand_ordy = 1'b0;
  endtask

  task automatic test_saturate_wrap();
    do_reset();
    for (int unsigned i = 0; i < 300; i++) begin
      beat(bad_word(), 0);
      exp_err = sat_inc(exp_err);
      if (i == 253 || i == 254 || i == 299) begin
        n_total++;
        if (err_count !== 8'(exp_err))
          $display("FAIL err_saturate: after %0d bad got %0d expected %0d", i + 1, err_count, exp_err);
        else n_pass++;
      end
    end
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 256; i++) begin
      beat({SYNC, 8'h00, 4'($urandom)}, 0);
      beat(16'($urandom), 0);
      beat(16'($urandom), 0);
      tick();
      exp_frames = (exp_frames + 1) % 256;
      if (i == 254 || i == 255) begin
        n_total++;
        if (frame_count !== 8'(exp_frames) || out_valid !== 1'b0)
          $display("FAIL frame_wrap: after %0d frames got frm=%0d v=%b expected frm=%0d v=0",
                   i + 1, frame_count, out_valid, exp_frames);
        else n_pass++;
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_header();
    test_hold();
    test_reset_mid();
    test_random(40);
    test_saturate_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
